// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with E/M and M/W registers, req/ack data-memory port, stall and timeout abort
// Optional feature macro: MISALIGN_CHECK_EN (misaligned memops abort instead of issuing a word-aligned request)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   *E_i                          execute-stage results latched into the E/M register
//   DMem*                         data-memory request/ack port, DMemErr_o pulses on abort
//   StallM_o                      freezes F/D/E and the E/M register while a request waits
//   RegWriteM_o/RdM_o/ALUResultM_o forwarding taps
//   *W_o                          M/W register toward writeback
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE_i,
  input  logic [1:0]        ResultSrcE_i,
  input  logic              MemWriteE_i,
  input  logic [31:0]       ALUResultE_i,
  input  logic [31:0]       WriteDataE_i,
  input  logic [4:0]        RdE_i,
  input  logic [31:0]       PCPlus4E_i,
  output logic              DMemReq_o,
  output logic              DMemWe_o,
  output logic [ADDR_W-1:0] DMemAddr_o,
  output logic [31:0]       DMemWData_o,
  input  logic              DMemAck_i,
  input  logic [31:0]       DMemRData_i,
  output logic              DMemErr_o,
  output logic              StallM_o,
  output logic              RegWriteM_o,
  output logic [4:0]        RdM_o,
  output logic [31:0]       ALUResultM_o,
  output logic              RegWriteW_o,
  output logic [1:0]        ResultSrcW_o,
  output logic [31:0]       ALUResultW_o,
  output logic [31:0]       ReadDataW_o,
  output logic [4:0]        RdW_o,
  output logic [31:0]       PCPlus4W_o
);
  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
  state_t      r_state, w_next;
  logic        r_regwrite_m, r_memwrite_m;
  logic [1:0]  r_resultsrc_m;
  logic [31:0] r_alu_m, r_wdata_m, r_pc4_m;
  logic [4:0]  r_rd_m;
  logic [7:0]  r_cnt;
  logic        w_memop, w_mis, w_load_done;
  assign w_memop = r_memwrite_m | (r_resultsrc_m == 2'b01);
`ifdef MISALIGN_CHECK_EN
  assign w_mis      = w_memop & (r_alu_m[1:0] != 2'b00);
  assign DMemAddr_o = r_alu_m[ADDR_W-1:0];
`else
  assign w_mis      = 1'b0;
  assign DMemAddr_o = {r_alu_m[ADDR_W-1:2], 2'b00};
`endif
  always_comb begin
    w_next    = r_state;
    DMemReq_o = 1'b0;
    DMemErr_o = 1'b0;
    case (r_state)
      IDLE: begin
        DMemReq_o = w_memop & ~w_mis;
        DMemErr_o = w_mis;
        w_next    = (DMemReq_o & ~DMemAck_i) ? WAIT : IDLE;
      end
      WAIT: begin
        DMemReq_o = 1'b1;
        w_next    = DMemAck_i ? IDLE : (r_cnt == 8'(TIMEOUT - 1)) ? ABORT : WAIT;
      end
      ABORT: begin
        DMemErr_o = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign StallM_o     = DMemReq_o & ~DMemAck_i;
  assign DMemWe_o     = r_memwrite_m;
  assign DMemWData_o  = r_wdata_m;
  assign RegWriteM_o  = r_regwrite_m;
  assign RdM_o        = r_rd_m;
  assign ALUResultM_o = r_alu_m;
  assign w_load_done  = DMemReq_o & DMemAck_i & ~r_memwrite_m;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_regwrite_m  <= 1'b0;
      r_resultsrc_m <= 2'b00;
      r_memwrite_m  <= 1'b0;
      r_alu_m       <= 32'd0;
      r_wdata_m     <= 32'd0;
      r_rd_m        <= 5'd0;
      r_pc4_m       <= 32'd0;
      RegWriteW_o   <= 1'b0;
      ResultSrcW_o  <= 2'b00;
      ALUResultW_o  <= 32'd0;
      ReadDataW_o   <= 32'd0;
      RdW_o         <= 5'd0;
      PCPlus4W_o    <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == WAIT) ? ((r_state == WAIT) ? r_cnt + 8'd1 : 8'd1) : 8'd0;
      if (!StallM_o) begin
        r_regwrite_m  <= RegWriteE_i;
        r_resultsrc_m <= ResultSrcE_i;
        r_memwrite_m  <= MemWriteE_i;
        r_alu_m       <= ALUResultE_i;
        r_wdata_m     <= WriteDataE_i;
        r_rd_m        <= RdE_i;
        r_pc4_m       <= PCPlus4E_i;
      end
      // stalled or aborted instructions reach W as an all-zero bubble
      if (StallM_o || DMemErr_o) begin
        RegWriteW_o  <= 1'b0;
        ResultSrcW_o <= 2'b00;
        ALUResultW_o <= 32'd0;
        ReadDataW_o  <= 32'd0;
        RdW_o        <= 5'd0;
        PCPlus4W_o   <= 32'd0;
      end else begin
        RegWriteW_o  <= r_regwrite_m & ~r_memwrite_m;
        ResultSrcW_o <= r_resultsrc_m;
        ALUResultW_o <= r_alu_m;
        ReadDataW_o  <= w_load_done ? DMemRData_i : 32'd0;
        RdW_o        <= r_rd_m;
        PCPlus4W_o   <= r_pc4_m;
      end
    end
  end
endmodule
